// File: rtl/gem_trig_pkg.sv
// rtl/gem_trig_pkg.sv - shared cluster, frame and scheduler state definitions
package gem_trig_pkg;

    localparam int CL_W     = 14;
    localparam int NUM_IN   = 8;
    localparam int NUM_SLOT = 4;

    localparam logic [10:0]     INVALID_ADDR = 11'h7FF;
    localparam logic [CL_W-1:0] PAD_DEFAULT  = 14'h3FFF;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } sched_state_t;

    // Slot 0 carries the oldest cluster and sits in the top bits of the frame.
    function automatic int slot_lsb(input int slot);
        return (NUM_SLOT - 1 - slot) * CL_W;
    endfunction

endpackage

// File: rtl/cluster_compactor.sv
// rtl/cluster_compactor.sv - packs the valid clusters of one BX in index order
module cluster_compactor
    import gem_trig_pkg::*;
(
    input  logic [NUM_IN*CL_W-1:0] clusters,
    output logic [NUM_IN*CL_W-1:0] packed_clusters,
    output logic [3:0]             count
);

    logic [NUM_IN-1:0] valid;
    logic [3:0]        offset [NUM_IN];
    logic [3:0]        acc;

    // Prefix popcount gives each valid cluster its slot; entry j lands at [14j+13:14j].
    always_comb begin
        valid           = '0;
        acc             = '0;
        packed_clusters = {NUM_IN{PAD_DEFAULT}};
        for (int i = 0; i < NUM_IN; i++) begin
            valid[i]  = clusters[i*CL_W +: 11] != INVALID_ADDR;
            offset[i] = acc;
            acc       = acc + {3'b000, valid[i]};
        end
        for (int j = 0; j < NUM_IN; j++) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (valid[i] && offset[i] == 4'(j)) begin
                    packed_clusters[j*CL_W +: CL_W] = clusters[i*CL_W +: CL_W];
                end
            end
        end
        count = acc;
    end

endmodule

// File: rtl/gem_cluster_scheduler.sv
// rtl/gem_cluster_scheduler.sv - buffers BX clusters and drains 4 per fiber frame
module gem_cluster_scheduler
    import gem_trig_pkg::*;
#(
    parameter int              DEPTH    = 16,
    parameter int              LOCK_CNT = 4,
    parameter logic [CL_W-1:0] PAD      = PAD_DEFAULT
) (
    input  logic                     TRG_CLK80,
    input  logic                     TRG_TXRESETDONE,
    input  logic [111:0]             CLUSTERS,
    input  logic                     CLUSTERS_VALID,
    input  logic                     OVERFLOW_IN,
    input  logic                     FRAME_STROBE,
    output logic [55:0]              GEM_DATA,
    output logic                     GEM_OVERFLOW,
    output logic                     LOCKED,
    output logic [$clog2(DEPTH):0]   FIFO_LEVEL,
    output logic [15:0]              DROP_CNT
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int LW = $clog2(LOCK_CNT + 1);

    sched_state_t          state_q;
    logic [1:0]            gap_q;
    logic [LW-1:0]         lock_q;
    logic [LW-1:0]         lock_next;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         level;
    logic                  sticky_q;
    logic [CL_W-1:0]       mem [DEPTH];
    logic [111:0]          comp_flat;
    logic [3:0]            count;
    logic                  run_fault;
    logic                  do_pop;
    logic                  do_push;
    logic                  set_event;
    logic [55:0]           frame_next;
    logic [AW-1:0]         rd_idx;
    int                    lvl_i;
    int                    pop_i;
    int                    space_i;
    int                    wr_i;
    int                    drop_i;
    int                    drop_sum;

    cluster_compactor u_compactor (
        .clusters        (CLUSTERS),
        .packed_clusters (comp_flat),
        .count           (count)
    );

    // Extra pointer MSB distinguishes full (MSBs differ, low bits equal) from empty.
    assign level      = wr_ptr - rd_ptr;
    assign FIFO_LEVEL = level;

    assign run_fault = (FRAME_STROBE && gap_q != 2'd2) || (!FRAME_STROBE && gap_q == 2'd3);
    assign do_pop    = (state_q == RUN) && FRAME_STROBE && !run_fault;
    assign do_push   = (state_q == RUN) && CLUSTERS_VALID && !run_fault;
    assign set_event = do_push && (drop_i != 0 || OVERFLOW_IN);
    assign lock_next = (gap_q == 2'd2 && lock_q != '0) ? lock_q + LW'(1) : LW'(1);

    // Pop is sized on pre-edge occupancy; the push then sees the space it freed.
    always_comb begin
        lvl_i   = int'(level);
        pop_i   = 0;
        wr_i    = 0;
        drop_i  = 0;
        if (do_pop) begin
            pop_i = (lvl_i > NUM_SLOT) ? NUM_SLOT : lvl_i;
        end
        space_i = DEPTH - (lvl_i - pop_i);
        if (do_push) begin
            wr_i   = (int'(count) > space_i) ? space_i : int'(count);
            drop_i = int'(count) - wr_i;
        end
        drop_sum = int'(DROP_CNT) + drop_i;
    end

    // Oldest min(level,4) entries fill the frame from slot 0; unused slots carry PAD.
    always_comb begin
        frame_next = {NUM_SLOT{PAD}};
        rd_idx     = '0;
        for (int s = 0; s < NUM_SLOT; s++) begin
            rd_idx = rd_ptr[AW-1:0] + AW'(s);
            if (s < pop_i) begin
                frame_next[slot_lsb(s) +: CL_W] = mem[rd_idx];
            end
        end
    end

    // Compacted clusters are written only into the space left after this edge's pop.
    always_ff @(posedge TRG_CLK80) begin
        for (int j = 0; j < NUM_IN; j++) begin
            if (j < wr_i) begin
                mem[wr_ptr[AW-1:0] + AW'(j)] <= comp_flat[j*CL_W +: CL_W];
            end
        end
    end

    // Strobe lock FSM with the FIFO pointers, frame outputs and drop accounting.
    always_ff @(posedge TRG_CLK80 or negedge TRG_TXRESETDONE) begin
        if (!TRG_TXRESETDONE) begin
            state_q      <= SYNC;
            gap_q        <= 2'd0;
            lock_q       <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            sticky_q     <= 1'b0;
            GEM_DATA     <= {NUM_SLOT{PAD}};
            GEM_OVERFLOW <= 1'b0;
            LOCKED       <= 1'b0;
            DROP_CNT     <= 16'h0000;
        end else begin
            if (FRAME_STROBE) begin
                gap_q <= 2'd1;
            end else if (gap_q != 2'd0 && gap_q != 2'd3) begin
                gap_q <= gap_q + 2'd1;
            end

            case (state_q)
                SYNC: begin
                    if (FRAME_STROBE) begin
                        if (lock_next == LW'(LOCK_CNT)) begin
                            state_q <= RUN;
                            LOCKED  <= 1'b1;
                            lock_q  <= '0;
                        end else begin
                            lock_q <= lock_next;
                        end
                    end
                end
                RUN: begin
                    if (run_fault) begin
                        state_q <= FLUSH;
                    end else begin
                        rd_ptr   <= rd_ptr + PW'(pop_i);
                        wr_ptr   <= wr_ptr + PW'(wr_i);
                        DROP_CNT <= (drop_sum > 65535) ? 16'hFFFF : 16'(drop_sum);
                        if (do_pop) begin
                            GEM_DATA     <= frame_next;
                            GEM_OVERFLOW <= sticky_q | set_event;
                            sticky_q     <= 1'b0;
                        end else begin
                            sticky_q <= sticky_q | set_event;
                        end
                    end
                end
                FLUSH: begin
                    state_q      <= SYNC;
                    lock_q       <= '0;
                    wr_ptr       <= '0;
                    rd_ptr       <= '0;
                    sticky_q     <= 1'b0;
                    GEM_DATA     <= {NUM_SLOT{PAD}};
                    GEM_OVERFLOW <= 1'b0;
                    LOCKED       <= 1'b0;
                end
                default: begin
                    state_q <= SYNC;
                end
            endcase
        end
    end

endmodule
